out_mem_wr_sched: RTL and testbench



---
 rtl/out_mem_pkg.sv | 14 +
 rtl/rr_arb2.sv | 18 +
 rtl/out_mem_wr_sched.sv | 88 ++++++++
 tb/tb_out_mem_wr_sched.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/out_mem_pkg.sv
// Shared constants and state type for the output pixel memory blocks.
package out_mem_pkg;

    localparam int PIX_COUNT = 76800;
    localparam int ADDR_W    = 17;
    localparam int DATA_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wr_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; rr picks the winner only when both lanes request.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       rr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/out_mem_wr_sched.sv
// Output pixel memory write scheduler: arbitrates two lanes, addresses pixels
// sequentially and flags the frame's last write.
//   state | meaning
//   IDLE  | waiting for start, no lane accepted
//   RUN   | accepting one pixel per cycle from the granted lane
//   DONE  | one cycle after the last write, then back to IDLE
module out_mem_wr_sched
    import out_mem_pkg::*;
#(
    parameter int PIX_TOTAL = PIX_COUNT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        lane_valid,
    input  logic [31:0]       lane0_result,
    input  logic [31:0]       lane1_result,
    output logic [1:0]        lane_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] pix_count
);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIX_TOTAL - 1);

    wr_state_t         state;
    logic              rr;
    logic [1:0]        grant;
    logic [DATA_W-1:0] sel_data;

    rr_arb2 u_arb (
        .valid (lane_valid),
        .rr    (rr),
        .grant (grant)
    );

    assign lane_ready = (state == RUN) ? grant : 2'b00;
    assign sel_data   = grant[1] ? lane1_result[DATA_W-1:0] : lane0_result[DATA_W-1:0];
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr         <= 1'b0;
            pix_count  <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            frame_done <= 1'b0;
        end else begin
            mem_we     <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        pix_count <= '0;
                        rr        <= 1'b0;
                    end
                end
                RUN: begin
                    if (|grant) begin
                        // Winner loses priority next time both lanes contend.
                        rr        <= grant[0];
                        mem_we    <= 1'b1;
                        mem_addr  <= pix_count;
                        mem_wdata <= sel_data;
                        pix_count <= pix_count + 1'b1;
                        if (pix_count == LAST_PIX) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_out_mem_wr_sched.sv
// Directed bench for out_mem_wr_sched with a 4-pixel frame.
module tb_out_mem_wr_sched;
    import out_mem_pkg::*;

    logic              clk;
    logic              rst;
    logic              start;
    logic [1:0]        lane_valid;
    logic [31:0]       lane0_result;
    logic [31:0]       lane1_result;
    logic [1:0]        lane_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;
    logic              frame_done;
    logic [ADDR_W-1:0] pix_count;

    int passed = 0;
    int total  = 0;

    out_mem_wr_sched #(.PIX_TOTAL(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .lane_valid   (lane_valid),
        .lane0_result (lane0_result),
        .lane1_result (lane1_result),
        .lane_ready   (lane_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .frame_done   (frame_done),
        .pix_count    (pix_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; lane_valid = 2'b11;
        lane0_result = 32'h0000_00AA; lane1_result = 32'h0000_00BB;
        tick(); tick();
        total++;
        if ({lane_ready, mem_we, mem_addr, mem_wdata, busy, frame_done, pix_count} !== '0)
            $display("FAIL reset: ready=%b we=%b addr=%0d wdata=%h busy=%b done=%b pix=%0d, expected all 0",
                     lane_ready, mem_we, mem_addr, mem_wdata, busy, frame_done, pix_count);
        else passed++;
        rst = 1'b0; lane_valid = 2'b00;
        tick();
        total++;
        if (busy !== 1'b0 || mem_we !== 1'b0)
            $display("FAIL idle_after_reset: busy=%b we=%b, expected 0 0", busy, mem_we);
        else passed++;
    endtask

    task automatic test_single_lane();
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1) $display("FAIL single_busy: got %b, expected 1", busy);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            lane_valid = 2'b01;
            lane0_result = {24'hDEADBE, vals[k]};
            #1;
            total++;
            if (lane_ready !== 2'b01) $display("FAIL single_ready[%0d]: got %b, expected 01", k, lane_ready);
            else passed++;
            tick();
            total++;
            if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(k) || mem_wdata !== vals[k] || pix_count !== ADDR_W'(k + 1))
                $display("FAIL single_write[%0d]: we=%b addr=%0d data=%h pix=%0d, expected 1 %0d %h %0d",
                         k, mem_we, mem_addr, mem_wdata, pix_count, k, vals[k], k + 1);
            else passed++;
        end
        lane_valid = 2'b00;
        tick();
        total++;
        if (mem_we !== 1'b0 || mem_addr !== ADDR_W'(2) || mem_wdata !== 8'h33 || pix_count !== ADDR_W'(3) || busy !== 1'b1)
            $display("FAIL single_hold: we=%b addr=%0d data=%h pix=%0d busy=%b, expected 0 2 33 3 1",
                     mem_we, mem_addr, mem_wdata, pix_count, busy);
        else passed++;
    endtask

    task automatic test_frame_end();
        lane_valid = 2'b01; lane0_result = 32'h0000_0044;
        tick();
        total++;
        if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(3) || mem_wdata !== 8'h44 || frame_done !== 1'b1 ||
            busy !== 1'b1 || pix_count !== ADDR_W'(4))
            $display("FAIL frame_last: we=%b addr=%0d data=%h done=%b busy=%b pix=%0d, expected 1 3 44 1 1 4",
                     mem_we, mem_addr, mem_wdata, frame_done, busy, pix_count);
        else passed++;
        total++;
        if (lane_ready !== 2'b00) $display("FAIL done_ready: got %b, expected 00", lane_ready);
        else passed++;
        tick();
        total++;
        if (mem_we !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0 || lane_ready !== 2'b00 || pix_count !== ADDR_W'(4))
            $display("FAIL frame_idle: we=%b done=%b busy=%b ready=%b pix=%0d, expected 0 0 0 00 4",
                     mem_we, frame_done, busy, lane_ready, pix_count);
        else passed++;
        lane_valid = 2'b00;
    endtask

    task automatic test_contention();
        logic [1:0] exp_rdy;
        logic [7:0] exp_d;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            lane_valid = 2'b11;
            lane0_result = 32'h0000_00A0 | k;
            lane1_result = 32'h0000_00B0 | k;
            exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_d   = (k % 2 == 0) ? (8'hA0 | 8'(k)) : (8'hB0 | 8'(k));
            #1;
            total++;
            if (lane_ready !== exp_rdy) $display("FAIL contend_ready[%0d]: got %b, expected %b", k, lane_ready, exp_rdy);
            else passed++;
            tick();
            total++;
            if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(k) || mem_wdata !== exp_d || frame_done !== (k == 3))
                $display("FAIL contend_write[%0d]: we=%b addr=%0d data=%h done=%b, expected 1 %0d %h %b",
                         k, mem_we, mem_addr, mem_wdata, frame_done, k, exp_d, k == 3);
            else passed++;
        end
        tick();
        total++;
        if (busy !== 1'b0 || mem_we !== 1'b0 || lane_ready !== 2'b00)
            $display("FAIL contend_fifth: busy=%b we=%b ready=%b, expected 0 0 00", busy, mem_we, lane_ready);
        else passed++;
        lane_valid = 2'b00;
    endtask

    task automatic test_start_during_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        lane_valid = 2'b01; lane0_result = 32'h0000_0001;
        tick(); tick();
        lane_valid = 2'b00;
        tick();
        total++;
        if (mem_we !== 1'b0 || pix_count !== ADDR_W'(2) || busy !== 1'b1)
            $display("FAIL run_stall: we=%b pix=%0d busy=%b, expected 0 2 1", mem_we, pix_count, busy);
        else passed++;
        start = 1'b1; lane_valid = 2'b01; lane0_result = 32'h0000_0077;
        tick();
        start = 1'b0;
        total++;
        if (pix_count !== ADDR_W'(3) || mem_addr !== ADDR_W'(2) || mem_wdata !== 8'h77 || mem_we !== 1'b1)
            $display("FAIL run_start_ignored: pix=%0d addr=%0d data=%h we=%b, expected 3 2 77 1",
                     pix_count, mem_addr, mem_wdata, mem_we);
        else passed++;
        tick();
        total++;
        if (pix_count !== ADDR_W'(4) || frame_done !== 1'b1 || mem_addr !== ADDR_W'(3))
            $display("FAIL run_finish: pix=%0d done=%b addr=%0d, expected 4 1 3", pix_count, frame_done, mem_addr);
        else passed++;
        lane_valid = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        lane_valid = 2'b01; lane0_result = 32'h0000_0009;
        tick(); tick();
        total++;
        if (pix_count !== ADDR_W'(2)) $display("FAIL mid_pre: pix=%0d, expected 2", pix_count);
        else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0; lane_valid = 2'b00;
        total++;
        if (mem_we !== 1'b0 || pix_count !== '0 || busy !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0)
            $display("FAIL mid_reset: we=%b pix=%0d busy=%b addr=%0d data=%h, expected 0 0 0 0 00",
                     mem_we, pix_count, busy, mem_addr, mem_wdata);
        else passed++;
        start = 1'b1;
        tick();
        start = 1'b0;
        lane_valid = 2'b10; lane1_result = 32'hFFFF_FF5A;
        #1;
        total++;
        if (lane_ready !== 2'b10) $display("FAIL lane1_ready: got %b, expected 10", lane_ready);
        else passed++;
        tick();
        lane_valid = 2'b00;
        total++;
        if (mem_we !== 1'b1 || mem_addr !== '0 || mem_wdata !== 8'h5A || pix_count !== ADDR_W'(1))
            $display("FAIL mid_restart: we=%b addr=%0d data=%h pix=%0d, expected 1 0 5a 1",
                     mem_we, mem_addr, mem_wdata, pix_count);
        else passed++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; lane_valid = 2'b00;
        lane0_result = '0; lane1_result = '0;
        test_reset();
        test_single_lane();
        test_frame_end();
        test_contention();
        test_start_during_run();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
